// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the delay-line tap sweep calibration block.
package delay_ctrl_pkg;

  localparam int TAP_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_LAUNCH  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } tap_sweep_state_t;

  // Strict majority: a tie between ones and zeros resolves to 0.
  function automatic logic majority(input int unsigned ones, input int unsigned samples);
    return ones > (samples / 32'd2);
  endfunction

endpackage

// File: rtl/delay_sample_counter.sv
// Per-tap launch/capture bookkeeping: counts captures and captured ones, reports majority.
module delay_sample_counter
  import delay_ctrl_pkg::*;
#(
  parameter int SAMPLES = 8,
  localparam int CNT_W = $clog2(SAMPLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cap_en,
  input  logic sample,
  output logic last_sample,
  output logic maj_bit
);

  logic [CNT_W-1:0] sample_cnt_r;
  logic [CNT_W-1:0] ones_cnt_r;

  // Counters cleared once per tap, stepped on each capture.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sample_cnt_r <= {CNT_W{1'b0}};
      ones_cnt_r   <= {CNT_W{1'b0}};
    end else if (cap_en) begin
      sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      ones_cnt_r   <= ones_cnt_r + {{(CNT_W-1){1'b0}}, sample};
    end else begin
      sample_cnt_r <= sample_cnt_r;
      ones_cnt_r   <= ones_cnt_r;
    end
  end

  // The capture in progress is the last one for this tap.
  assign last_sample = (sample_cnt_r == CNT_W'(SAMPLES - 1));
  assign maj_bit     = majority(32'(ones_cnt_r), 32'(SAMPLES));

endmodule

// File: rtl/delay_tap_sweep_ctrl.sv
// Tap sweep sequencer with manual tap arbitration in idle.
// Optional per-tap majority map built when DELAY_TAP_MAP_EN is defined.
module delay_tap_sweep_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int TAP_W      = TAP_W_DEF,
  parameter int SETTLE_CYC = 4,
  parameter int SAMPLES    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  manual_en,
  input  logic [TAP_W-1:0]      manual_tap,
  input  logic                  dl_sample,
  output logic [TAP_W-1:0]      tap_sel,
  output logic                  launch,
  output logic                  busy,
  output logic                  done,
  output logic                  lock_valid,
  output logic [TAP_W-1:0]      lock_tap,
  output logic [2**TAP_W-1:0]   tap_map
);

  localparam int NTAPS = 2**TAP_W;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

  tap_sweep_state_t state_r, state_next_s;
  logic [SET_W-1:0] settle_cnt_r;
  logic [TAP_W-1:0] idx_r, idx_next_s;
  logic [TAP_W-1:0] tap_sel_r, lock_tap_r;
  logic             launch_r, busy_r, done_r, lock_valid_r, ref_r;
  logic             clr_s, cap_s, last_sample_s, maj_s, sweep_go_s;

  assign sweep_go_s = (state_r == ST_IDLE) && start;

  delay_sample_counter #(.SAMPLES(SAMPLES)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr_s),
    .cap_en      (cap_s),
    .sample      (dl_sample),
    .last_sample (last_sample_s),
    .maj_bit     (maj_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state, tap index and counter controls.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    clr_s        = 1'b0;
    cap_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_SET;
          idx_next_s   = {TAP_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SET: begin
        clr_s        = 1'b1;
        state_next_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_r == SET_W'(SETTLE_CYC - 1)) state_next_s = ST_LAUNCH;
        else                                        state_next_s = ST_SETTLE;
      end
      ST_LAUNCH: state_next_s = ST_CAPTURE;
      ST_CAPTURE: begin
        cap_s = 1'b1;
        if (last_sample_s) state_next_s = ST_NEXT;
        else               state_next_s = ST_LAUNCH;
      end
      ST_NEXT: begin
        if (idx_r == LAST_TAP) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SET;
          idx_next_s   = idx_r + TAP_W'(1);
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Registered outputs, tap select arbitration and lock tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= {SET_W{1'b0}};
      idx_r        <= {TAP_W{1'b0}};
      tap_sel_r    <= {TAP_W{1'b0}};
      launch_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      lock_valid_r <= 1'b0;
      lock_tap_r   <= {TAP_W{1'b0}};
      ref_r        <= 1'b0;
    end else begin
      settle_cnt_r <= (state_r == ST_SETTLE) ? settle_cnt_r + SET_W'(1) : {SET_W{1'b0}};
      idx_r        <= idx_next_s;
      launch_r     <= (state_next_s == ST_LAUNCH);
      busy_r       <= (state_next_s != ST_IDLE);
      done_r       <= (state_next_s == ST_DONE);
      // A sweep start overrides a simultaneous manual request.
      if (state_next_s == ST_SET)                tap_sel_r <= idx_next_s;
      else if (state_r == ST_IDLE && manual_en)  tap_sel_r <= manual_tap;
      if (sweep_go_s) begin
        lock_valid_r <= 1'b0;
        lock_tap_r   <= {TAP_W{1'b0}};
      end else if (state_r == ST_NEXT) begin
        if (idx_r == {TAP_W{1'b0}}) begin
          ref_r <= maj_s;
        end else if ((maj_s != ref_r) && !lock_valid_r) begin
          lock_valid_r <= 1'b1;
          lock_tap_r   <= idx_r;
        end
      end
    end
  end

`ifdef DELAY_TAP_MAP_EN
  logic [NTAPS-1:0] tap_map_r;

  // Per-tap majority map, cleared with the lock result at sweep start.
  always_ff @(posedge clk) begin
    if (rst || sweep_go_s)       tap_map_r <= {NTAPS{1'b0}};
    else if (state_r == ST_NEXT) tap_map_r[idx_r] <= maj_s;
    else                         tap_map_r <= tap_map_r;
  end

  assign tap_map = tap_map_r;
`else
  assign tap_map = {NTAPS{1'b0}};
`endif

  assign tap_sel    = tap_sel_r;
  assign launch     = launch_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign lock_valid = lock_valid_r;
  assign lock_tap   = lock_tap_r;

endmodule

// File: tb/tb_delay_tap_sweep_ctrl.sv
// Self-checking bench for delay_tap_sweep_ctrl: vector table of per-tap ones counts plus a done scoreboard.
module tb_delay_tap_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, manual_en, dl_sample;
  logic [2:0] manual_tap, tap_sel, lock_tap;
  logic       launch, busy, done, lock_valid;
  logic [7:0] tap_map;

  delay_tap_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .manual_en(manual_en), .manual_tap(manual_tap),
    .dl_sample(dl_sample), .tap_sel(tap_sel), .launch(launch), .busy(busy), .done(done),
    .lock_valid(lock_valid), .lock_tap(lock_tap), .tap_map(tap_map)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][3:0] ones;
    logic            lv;
    logic [2:0]      lt;
    logic [7:0]      map;
  } vec_t;

  typedef struct {
    logic       lv;
    logic [2:0] lt;
    logic [7:0] map;
    int         cyc;
    int         launches;
  } exp_t;

  vec_t vecs[6];
  exp_t sc_q[$];
  logic [7:0][3:0] ones_cur;
  int checks = 0, errors = 0;
  int cyc = 0, launch_total = 0;
  int lcnt = 0;
  logic [2:0] last_tap_b = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Delay-line model: the k-th capture of a tap returns 1 while k <= ones_cur[tap].
  always @(negedge clk) begin
    if (!busy || tap_sel != last_tap_b) begin
      lcnt = 0;
      last_tap_b = tap_sel;
    end
    if (launch) begin
      lcnt++;
      launch_total++;
    end
    dl_sample = (lcnt != 0) && (lcnt <= int'(ones_cur[tap_sel]));
  end

  // Scoreboard monitor: every done pulse must match the oldest expected sweep.
  always @(negedge clk) begin
    if (done) begin
      if (sc_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sc_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("launch_count", launch_total - e.launches, 32'd64);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        chk("lock_valid", {31'd0, lock_valid}, {31'd0, e.lv});
        chk("lock_tap", {29'd0, lock_tap}, {29'd0, e.lt});
        chk("tap_map", {24'd0, tap_map}, {24'd0, e.map});
      end
    end
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.lv = v.lv;
    e.lt = v.lt;
`ifdef DELAY_TAP_MAP_EN
    e.map = v.map;
`else
    e.map = 8'h00;
`endif
    e.cyc = cyc + 177;
    e.launches = launch_total;
    sc_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sc_q.size() != 0; i++) @(negedge clk);
    if (sc_q.size() != 0) begin
      chk("done_timeout", sc_q.size(), 32'd0);
      sc_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tap_sel"}, {29'd0, tap_sel}, 32'd0);
    chk({tag, "_launch"}, {31'd0, launch}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_lock_valid"}, {31'd0, lock_valid}, 32'd0);
    chk({tag, "_lock_tap"}, {29'd0, lock_tap}, 32'd0);
    chk({tag, "_tap_map"}, {24'd0, tap_map}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    ones_cur = v.ones;
    start = 1'b1;
    push_exp(v);
    @(negedge clk);
    start = 1'b0;
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
    chk("tap_sel_in_set", {29'd0, tap_sel}, 32'd0);
    wait_done();
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("tap_sel_hold_last", {29'd0, tap_sel}, 32'd7);
  endtask

  initial begin
    // ones per tap (tap 0 in the low nibble), lock_valid, lock_tap, tap_map
    vecs[0] = '{32'h0000_0888, 1'b1, 3'd3, 8'h07};
    vecs[1] = '{32'h8888_8888, 1'b0, 3'd0, 8'hFF};
    vecs[2] = '{32'h8888_4588, 1'b1, 3'd3, 8'hF7};
    vecs[3] = '{32'h0000_0000, 1'b0, 3'd0, 8'h00};
    vecs[4] = '{32'h5000_0000, 1'b1, 3'd7, 8'h80};
    vecs[5] = '{32'h4444_4454, 1'b1, 3'd1, 8'h02};

    rst = 1'b1; start = 1'b0; manual_en = 1'b0; manual_tap = 3'd0;
    ones_cur = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort a sweep at cycle 50, then a fresh sweep with different data.
    ones_cur = vecs[0].ones;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_busy_after_rst", {31'd0, busy}, 32'd0);
    run_vec(vecs[2]);

    // Manual request in idle.
    manual_en = 1'b1; manual_tap = 3'd5;
    @(negedge clk);
    manual_en = 1'b0;
    chk("manual_tap_sel", {29'd0, tap_sel}, 32'd5);
    @(negedge clk);
    chk("manual_hold", {29'd0, tap_sel}, 32'd5);

    // Start wins over a simultaneous manual request; requests while busy are ignored.
    ones_cur = vecs[0].ones;
    start = 1'b1; manual_en = 1'b1; manual_tap = 3'd2;
    push_exp(vecs[0]);
    @(negedge clk);
    start = 1'b0; manual_en = 1'b0;
    chk("start_wins_tap_sel", {29'd0, tap_sel}, 32'd0);
    chk("start_wins_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    start = 1'b1; manual_en = 1'b1; manual_tap = 3'd6;
    repeat (3) @(negedge clk);
    start = 1'b0; manual_en = 1'b0;
    chk("busy_ignores_manual", {29'd0, tap_sel}, 32'd0);
    wait_done();
    repeat (5) @(negedge clk);
    chk("no_queued_start", {31'd0, busy}, 32'd0);
    chk("final_tap_sel", {29'd0, tap_sel}, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
